// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER fetch path: PC source encodings,
// fetch FSM states and the default reset vector.
package otter_pkg;

  localparam logic [2:0] PC_SEQ  = 3'd0;
  localparam logic [2:0] PC_JAL  = 3'd1;
  localparam logic [2:0] PC_BR   = 3'd2;
  localparam logic [2:0] PC_JALR = 3'd3;
  localparam logic [2:0] PC_TRAP = 3'd4;
  localparam logic [2:0] PC_MRET = 3'd5;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/otter_pc_target_mux.sv
// Combinational redirect decode: picks the target for the requested PC source,
// decides whether the redirect is taken and whether it must be rejected as misaligned.
module otter_pc_target_mux
  import otter_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        redirect_valid_i,
  input  logic [2:0]  pc_sel_i,
  input  logic        branch_taken_i,
  input  logic [31:0] jal_addr_i,
  input  logic [31:0] branch_addr_i,
  input  logic [31:0] jalr_addr_i,
  input  logic [31:0] trap_vec_i,
  input  logic [31:0] epc_i,
  output logic        redirect_o,
  output logic        misalign_o,
  output logic [31:0] target_o
);

  logic take;
  logic check_align;
  logic misaligned;

  always_comb begin
    take        = 1'b0;
    check_align = 1'b0;
    target_o    = 32'h0000_0000;
    case (pc_sel_i)
      PC_JAL: begin
        take        = 1'b1;
        check_align = 1'b1;
        target_o    = jal_addr_i;
      end
      PC_BR: begin
        take        = branch_taken_i;
        check_align = 1'b1;
        target_o    = branch_addr_i;
      end
      PC_JALR: begin
        take        = 1'b1;
        check_align = 1'b1;
        target_o    = jalr_addr_i;
      end
      // Trap and return targets are forced to word alignment, so never rejected
      PC_TRAP: begin
        take     = 1'b1;
        target_o = word_align(trap_vec_i);
      end
      PC_MRET: begin
        take     = 1'b1;
        target_o = word_align(epc_i);
      end
      default: take = 1'b0;
    endcase
    take       = take & redirect_valid_i;
    misaligned = ALIGN_CHECK && check_align && (target_o[1:0] != 2'b00);
    redirect_o = take & ~misaligned;
    misalign_o = take & misaligned;
  end

endmodule

// File: rtl/otter_pc_sequencer.sv
// OTTER program counter and fetch sequencer: single-outstanding imem handshake,
// one held instruction toward decode, redirects kill any in-flight response.
module otter_pc_sequencer
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VEC   = RESET_VEC_DEFAULT,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [2:0]  pc_sel,
  input  logic        branch_taken,
  input  logic [31:0] jal_addr,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jalr_addr,
  input  logic [31:0] trap_vec,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc,
  output logic        misalign_exc,
  output logic [31:0] misalign_addr
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic [31:0]  misalign_addr_q, misalign_addr_d;
  logic         misalign_exc_q, misalign_exc_d;
  logic         kill_q, kill_d;

  logic         tgt_redirect;
  logic         tgt_misalign;
  logic [31:0]  tgt_addr;

  otter_pc_target_mux #(
    .ALIGN_CHECK(ALIGN_CHECK)
  ) u_target_mux (
    .redirect_valid_i(redirect_valid),
    .pc_sel_i        (pc_sel),
    .branch_taken_i  (branch_taken),
    .jal_addr_i      (jal_addr),
    .branch_addr_i   (branch_addr),
    .jalr_addr_i     (jalr_addr),
    .trap_vec_i      (trap_vec),
    .epc_i           (epc),
    .redirect_o      (tgt_redirect),
    .misalign_o      (tgt_misalign),
    .target_o        (tgt_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_VEC;
      kill_q          <= 1'b0;
      instr_q         <= 32'h0000_0000;
      instr_pc_q      <= 32'h0000_0000;
      misalign_exc_q  <= 1'b0;
      misalign_addr_q <= 32'h0000_0000;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      kill_q          <= kill_d;
      instr_q         <= instr_d;
      instr_pc_q      <= instr_pc_d;
      misalign_exc_q  <= misalign_exc_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    kill_d          = kill_q;
    instr_d         = instr_q;
    instr_pc_d      = instr_pc_q;
    misalign_exc_d  = tgt_misalign;
    misalign_addr_d = tgt_misalign ? tgt_addr : misalign_addr_q;
    if (tgt_redirect) begin
      pc_d = tgt_addr;
    end
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          kill_d  = tgt_redirect;
        end
      end
      S_WAIT: begin
        // A response belonging to a redirected-away PC is dropped and refetched
        if (imem_rvalid) begin
          if (kill_q || tgt_redirect) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            state_d    = S_HOLD;
          end
        end else if (tgt_redirect) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (tgt_redirect) begin
          state_d = S_REQ;
        end else if (instr_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req      = (state_q == S_REQ);
    imem_addr     = pc_q;
    instr_valid   = (state_q == S_HOLD);
    instr         = instr_q;
    instr_pc      = instr_pc_q;
    pc            = pc_q;
    misalign_exc  = misalign_exc_q;
    misalign_addr = misalign_addr_q;
  end

endmodule

// File: tb/tb_otter_pc_sequencer.sv
// Directed bench for otter_pc_sequencer with a zero-wait imem responder
// that can be switched to manual gnt/rvalid control.
module tb_otter_pc_sequencer;
  import otter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [2:0]  pc_sel;
  logic        branch_taken;
  logic [31:0] jal_addr, branch_addr, jalr_addr, trap_vec, epc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr, instr_pc, pc;
  logic        misalign_exc;
  logic [31:0] misalign_addr;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          req_cyc = 0;
  logic        auto_mem = 1'b0;
  logic        man_gnt = 1'b0;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic        pend_q = 1'b0;
  logic [31:0] pend_addr_q = 32'h0;
  bit          saw_bad = 1'b0;

  always #5 clk = ~clk;

  otter_pc_sequencer #(
    .RESET_VEC  (32'h0000_0000),
    .ALIGN_CHECK(1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .pc_sel        (pc_sel),
    .branch_taken  (branch_taken),
    .jal_addr      (jal_addr),
    .branch_addr   (branch_addr),
    .jalr_addr     (jalr_addr),
    .trap_vec      (trap_vec),
    .epc           (epc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc            (pc),
    .misalign_exc  (misalign_exc),
    .misalign_addr (misalign_addr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Zero-wait memory: grant whenever requested, answer on the next cycle
  assign imem_gnt    = auto_mem ? imem_req : man_gnt;
  assign imem_rvalid = auto_mem ? pend_q : man_rvalid;
  assign imem_rdata  = auto_mem ? mem_word(pend_addr_q) : man_rdata;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    pend_q <= imem_req & imem_gnt;
    if (imem_req & imem_gnt) pend_addr_q <= imem_addr;
  end

  always @(negedge clk) begin
    if (instr_valid && instr == 32'hDEAD_BEEF) saw_bad = 1'b1;
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input logic [31:0] a);
    int k = 0;
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    expect_eq("req_seen", {31'b0, imem_req}, 32'd1);
    expect_eq("imem_addr", imem_addr, a);
    req_cyc = cyc;
  endtask

  task automatic wait_valid(input logic [31:0] a);
    int k = 0;
    while (!instr_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    expect_eq("valid_seen", {31'b0, instr_valid}, 32'd1);
    expect_eq("instr", instr, mem_word(a));
    expect_eq("instr_pc", instr_pc, a);
    $display("fetch pc=%h instr=%h", instr_pc, instr);
  endtask

  task automatic fetch_one(input logic [31:0] a, input logic rdy);
    wait_req(a);
    instr_ready = rdy;
    wait_valid(a);
  endtask

  // Non-selected sources carry a decoy so a wrong mux pick shows up as fetch 0x800
  task automatic redirect(input logic [2:0] sel, input logic [31:0] a);
    jal_addr       = (sel == PC_JAL)  ? a : 32'h0000_0800;
    branch_addr    = (sel == PC_BR)   ? a : 32'h0000_0800;
    jalr_addr      = (sel == PC_JALR) ? a : 32'h0000_0800;
    trap_vec       = (sel == PC_TRAP) ? a : 32'h0000_0800;
    epc            = (sel == PC_MRET) ? a : 32'h0000_0800;
    pc_sel         = sel;
    redirect_valid = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    pc_sel         = PC_SEQ;
    branch_taken   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    pc_sel = PC_SEQ;
    branch_taken = 1'b0;
    jal_addr = 32'h0; branch_addr = 32'h0; jalr_addr = 32'h0;
    trap_vec = 32'h0; epc = 32'h0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);

    expect_eq("rst_imem_req", {31'b0, imem_req}, 32'd0);
    expect_eq("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    expect_eq("rst_instr", instr, 32'h0);
    expect_eq("rst_instr_pc", instr_pc, 32'h0);
    expect_eq("rst_pc", pc, 32'h0);
    expect_eq("rst_misalign_exc", {31'b0, misalign_exc}, 32'd0);
    expect_eq("rst_misalign_addr", misalign_addr, 32'h0);

    // Sequential fetch, one instruction every 3 cycles
    rst = 1'b0;
    auto_mem = 1'b1;
    instr_ready = 1'b1;
    fetch_one(32'h0, 1'b1);
    c0 = req_cyc;
    fetch_one(32'h4, 1'b1);
    expect_eq("fetch_rate", req_cyc - c0, 32'd3);
    fetch_one(32'h8, 1'b1);

    // Decode stall
    fetch_one(32'hC, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_eq("stall_valid", {31'b0, instr_valid}, 32'd1);
      expect_eq("stall_instr", instr, mem_word(32'hC));
      expect_eq("stall_instr_pc", instr_pc, 32'hC);
      expect_eq("stall_req", {31'b0, imem_req}, 32'd0);
      expect_eq("stall_pc", pc, 32'hC);
    end
    instr_ready = 1'b1;

    // JAL in S_WAIT; stale response two cycles later must be dropped
    wait_req(32'h10);
    @(negedge clk);
    auto_mem = 1'b0;
    redirect(PC_JAL, 32'h100);
    expect_eq("jal_pc", pc, 32'h100);
    expect_eq("jal_wait_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    man_rvalid = 1'b1;
    man_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    man_rvalid = 1'b0;
    expect_eq("kill_req", {31'b0, imem_req}, 32'd1);
    expect_eq("kill_addr", imem_addr, 32'h100);
    expect_eq("kill_valid", {31'b0, instr_valid}, 32'd0);
    auto_mem = 1'b1;
    fetch_one(32'h100, 1'b1);

    // Branch not taken, then taken
    wait_req(32'h104);
    branch_taken = 1'b0;
    redirect(PC_BR, 32'h40);
    expect_eq("br_nt_pc", pc, 32'h104);
    wait_valid(32'h104);
    wait_req(32'h108);
    branch_taken = 1'b1;
    redirect(PC_BR, 32'h40);
    fetch_one(32'h40, 1'b1);

    // Misaligned JALR rejected, then trap with low bits forced to zero
    fetch_one(32'h44, 1'b0);
    redirect(PC_JALR, 32'h102);
    expect_eq("mis_exc", {31'b0, misalign_exc}, 32'd1);
    expect_eq("mis_addr", misalign_addr, 32'h102);
    expect_eq("mis_pc", pc, 32'h44);
    expect_eq("mis_valid", {31'b0, instr_valid}, 32'd1);
    expect_eq("mis_instr_pc", instr_pc, 32'h44);
    @(negedge clk);
    expect_eq("mis_pulse_end", {31'b0, misalign_exc}, 32'd0);
    expect_eq("mis_addr_held", misalign_addr, 32'h102);
    redirect(PC_TRAP, 32'h203);
    expect_eq("trap_req", {31'b0, imem_req}, 32'd1);
    expect_eq("trap_addr", imem_addr, 32'h200);
    expect_eq("trap_valid", {31'b0, instr_valid}, 32'd0);
    expect_eq("trap_no_exc", {31'b0, misalign_exc}, 32'd0);
    fetch_one(32'h200, 1'b1);

    // Asynchronous reset while waiting for a response
    wait_req(32'h204);
    auto_mem = 1'b0;
    man_gnt  = 1'b1;
    @(negedge clk);
    man_gnt = 1'b0;
    expect_eq("pre_rst_wait", {31'b0, imem_req}, 32'd0);
    #2 rst = 1'b1;
    #1;
    expect_eq("arst_pc", pc, 32'h0);
    expect_eq("arst_instr", instr, 32'h0);
    expect_eq("arst_instr_pc", instr_pc, 32'h0);
    expect_eq("arst_valid", {31'b0, instr_valid}, 32'd0);
    expect_eq("arst_req", {31'b0, imem_req}, 32'd0);
    expect_eq("arst_misalign_addr", misalign_addr, 32'h0);
    @(negedge clk);
    man_rvalid = 1'b1;
    man_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    man_rvalid = 1'b0;
    expect_eq("post_rst_req", {31'b0, imem_req}, 32'd1);
    expect_eq("post_rst_addr", imem_addr, 32'h0);
    expect_eq("post_rst_valid", {31'b0, instr_valid}, 32'd0);
    auto_mem = 1'b1;
    fetch_one(32'h0, 1'b1);

    // MRET target alignment, then PC+4 wraparound
    wait_req(32'h4);
    redirect(PC_MRET, 32'h307);
    fetch_one(32'h304, 1'b1);
    wait_req(32'h308);
    redirect(PC_JAL, 32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, 1'b1);
    fetch_one(32'h0, 1'b1);

    expect_eq("no_stale_data", {31'b0, saw_bad}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/otter_pc_sequencer.md
Name: otter_pc_sequencer

Overview:
Owns the program counter and sequences instruction fetch for the OTTER core. Selects the next PC from sequential PC+4, JAL, branch, JALR targets (from the branch address generator), the trap vector or the MRET return address. Runs a single-outstanding request/grant/response handshake to instruction memory and presents one instruction at a time to decode with a valid/ready handshake. Sits between the branch address generator/CSR unit and imem/decode.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset
ALIGN_CHECK, 1, 1 = raise misalign_exc for targets with [1:0] != 0 (no compressed ISA)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
redirect_valid  in  1  pc_sel/target valid this cycle
pc_sel  in  3  0 seq(ignored), 1 jal, 2 branch, 3 jalr, 4 trap, 5 mret, 6-7 ignored
branch_taken  in  1  qualifies pc_sel==2; not taken = no redirect
jal_addr, branch_addr, jalr_addr, trap_vec, epc  in  32 each  candidate targets
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc)
imem_gnt  in  1  request accepted
imem_rvalid  in  1  response data valid
imem_rdata  in  32  response instruction
instr_valid  out  1  instruction available to decode
instr_ready  in  1  decode consumes instruction
instr  out  32  held instruction
instr_pc  out  32  PC of held instruction
pc  out  32  current fetch PC
misalign_exc  out  1  one-cycle pulse, misaligned target rejected
misalign_addr  out  32  offending target, held until next pulse

Behaviour:
- Reset (async): pc=RESET_VEC, state S_IDLE, kill=0, instr_valid=0, instr=0, instr_pc=0, misalign_exc=0, misalign_addr=0; imem_req=0.
- States: S_IDLE -> S_REQ unconditionally next cycle. S_REQ: imem_req=1, imem_addr=pc; gnt -> S_WAIT. S_WAIT: on rvalid, if kill: discard, kill<=0, -> S_REQ; else instr<=rdata, instr_pc<=pc, instr_valid<=1, -> S_HOLD. S_HOLD: instr_valid=1; instr_ready -> pc<=pc+4 (mod 2^32), instr_valid<=0, -> S_REQ.
- Accepted redirect = redirect_valid & pc_sel in {1,3,4,5}, or pc_sel==2 & branch_taken. Trap/mret targets have [1:0] forced to 0 and are never misaligned.
- Misaligned jal/branch/jalr target (ALIGN_CHECK=1): misalign_exc=1 next cycle, misalign_addr=target, pc/state/instr_valid unchanged; CSR unit then issues trap redirect.
- Accepted aligned redirect overrides sequential advance in every state: pc<=target next cycle.
  - S_IDLE/S_REQ without gnt: -> S_REQ; imem_addr may change while ungranted.
  - S_REQ with gnt same cycle: -> S_WAIT, kill<=1.
  - S_WAIT: stay, kill<=1 (rvalid same cycle: discard, -> S_REQ).
  - S_HOLD: instr_valid<=0, -> S_REQ, instr_ready ignored.
- Latency: redirect at cycle N -> imem_req with target at N+1 when not in S_WAIT. Zero-wait memory (gnt in S_REQ, rvalid next cycle) -> instr_valid 2 cycles after S_REQ entry.
- One outstanding request max; rvalid outside S_WAIT ignored.
- pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.

Decomposition:
- Shared package otter_pkg: pc_sel encodings (PC_SEQ, PC_JAL, PC_BR, PC_JALR, PC_TRAP, PC_MRET), fetch state enum, RESET_VEC default.
- One sub-module natural: otter_pc_target_mux (combinational target select, accept and misalign decode); FSM, pc and instruction registers stay in top.

Test Plan:
- Reset release, gnt/rvalid zero-wait, instr_ready=1 -> imem_addr 0x0, 0x4, 0x8; instr_pc matches; one instruction every 3 cycles.
- instr_ready=0 for 5 cycles in S_HOLD -> instr/instr_pc stable, imem_req=0, pc unchanged.
- jal redirect to 0x100 while in S_WAIT, rvalid 2 cycles later with 0xDEADBEEF -> data discarded, next imem_addr=0x100, instr_valid never shows 0xDEADBEEF.
- pc_sel=2, branch_taken=0, branch_addr=0x40 -> no redirect; branch_taken=1 -> next fetch 0x40.
- jalr_addr=0x102 -> misalign_exc one cycle, misalign_addr=0x102, pc unchanged; following trap redirect with trap_vec=0x203 -> fetch 0x200.
- Assert rst mid S_WAIT, then release -> all outputs reset values, first fetch RESET_VEC, late rvalid ignored.
